// File: rtl/led_band_fc_receiver.sv
// ---------------------------------------------------------------------------
// led_band_fc_receiver
//
// Purpose:
//   Receives 48-bit FC (function control) words from an LED-band style serial
//   interface (SCLK / SIN / LAT) that is asynchronous to the system clock.
//   The number of SCLK rising edges seen while LAT is high forms a command:
//     15 -> FCWRTEN : arm the receiver and start collecting a new FC word
//      5 -> WRTFC   : commit the collected 48 bits to fc_data
//   While armed, SCLK rising edges with LAT low shift SIN in MSB first.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   SCLK         in   serial clock (asynchronous)
//   SIN          in   serial data, MSB first
//   LAT          in   latch / command line
//   fc_data      out  [47:0] last FC word accepted
//   fc_valid     out  one-clk pulse when fc_data updates
//   fc_error     out  one-clk pulse when a frame/command is rejected
//   fc_err_code  out  [1:0] cause of the last error (held)
//                     1 = WRTFC with wrong bit count
//                     2 = FCWRTEN/other command while armed
//                     3 = WRTFC while idle
//   armed        out  high while FC data is being received
//   fc_err_count out  [7:0] saturating error count (only with the macro below)
//
// Build option:
//   LED_FC_RX_ERRCNT_EN  adds the fc_err_count output and its counter.
// ---------------------------------------------------------------------------
module led_band_fc_receiver (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCLK,
    input  logic        SIN,
    input  logic        LAT,
    output logic [47:0] fc_data,
    output logic        fc_valid,
    output logic        fc_error,
    output logic [1:0]  fc_err_code,
    output logic        armed
`ifdef LED_FC_RX_ERRCNT_EN
    ,
    output logic [7:0]  fc_err_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CMD_OTHER   = 2'd0,
        CMD_FCWRTEN = 2'd1,
        CMD_WRTFC   = 2'd2
    } cmd_t;

    localparam logic [4:0] LAT_FCWRTEN = 5'd15;
    localparam logic [4:0] LAT_WRTFC   = 5'd5;
    localparam logic [5:0] BITS_FULL   = 6'd48;
    localparam logic [5:0] BITS_OVF    = 6'd49;

    // Synchronisers and edge detection
    logic [1:0]  r_sclkSync;
    logic [1:0]  r_sinSync;
    logic [1:0]  r_latSync;
    logic        r_sclkPrev;
    logic [1:0]  r_guard;

    // Command decode
    logic [4:0]  r_latCnt;
    logic        r_cmdValid;
    cmd_t        r_cmd;

    // Frame collection
    logic [47:0] r_shift;
    logic [5:0]  r_bitCnt;

    // FSM and outputs
    state_t      r_state;
    state_t      w_nextState;
    logic        w_loadOut;
    logic        w_err;
    logic [1:0]  w_errCode;
    logic        w_clearFrame;

    logic [47:0] r_fcData;
    logic        r_fcValid;
    logic        r_fcError;
    logic [1:0]  r_fcErrCode;

    logic        w_sclkRise;
    logic        w_latHigh;
    logic        w_decode;
    cmd_t        w_decodedCmd;

    // Identical two-flop synchronisers for all three serial lines. The guard
    // counter keeps edge detection off for the first three cycles after reset
    // so that a line already high at release cannot look like a fresh edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclkSync <= '0;
            r_sinSync  <= '0;
            r_latSync  <= '0;
            r_sclkPrev <= 1'b0;
            r_guard    <= '0;
        end else begin
            r_sclkSync <= {r_sclkSync[0], SCLK};
            r_sinSync  <= {r_sinSync[0], SIN};
            r_latSync  <= {r_latSync[0], LAT};
            r_sclkPrev <= r_sclkSync[1];
            if (r_guard != 2'd3) begin
                r_guard <= r_guard + 2'd1;
            end
        end
    end

    assign w_sclkRise = r_sclkSync[1] & ~r_sclkPrev & (r_guard == 2'd3);
    assign w_latHigh  = r_latSync[1];
    assign w_decode   = ~w_latHigh & (r_latCnt != 5'd0);

    always_comb begin
        w_decodedCmd = CMD_OTHER;
        if (r_latCnt == LAT_FCWRTEN) begin
            w_decodedCmd = CMD_FCWRTEN;
        end else if (r_latCnt == LAT_WRTFC) begin
            w_decodedCmd = CMD_WRTFC;
        end
    end

    // Latch counter counts SCLK edges under LAT and is decoded into a
    // registered command on the first LAT-low cycle; this is the decode stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_latCnt   <= '0;
            r_cmdValid <= 1'b0;
            r_cmd      <= CMD_OTHER;
        end else begin
            r_cmdValid <= w_decode;
            if (w_decode) begin
                r_cmd <= w_decodedCmd;
            end
            if (w_latHigh && w_sclkRise) begin
                if (r_latCnt != 5'd31) begin
                    r_latCnt <= r_latCnt + 5'd1;
                end
            end else if (w_decode) begin
                r_latCnt <= '0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state and command handling
    always_comb begin
        w_nextState  = r_state;
        w_loadOut    = 1'b0;
        w_err        = 1'b0;
        w_errCode    = 2'd0;
        w_clearFrame = 1'b0;
        if (r_cmdValid) begin
            case (r_state)
                IDLE: begin
                    if (r_cmd == CMD_FCWRTEN) begin
                        w_nextState  = ARMED;
                        w_clearFrame = 1'b1;
                    end else if (r_cmd == CMD_WRTFC) begin
                        w_err     = 1'b1;
                        w_errCode = 2'd3;
                    end
                end
                ARMED: begin
                    if (r_cmd == CMD_WRTFC) begin
                        w_nextState = IDLE;
                        if (r_bitCnt == BITS_FULL) begin
                            w_loadOut = 1'b1;
                        end else begin
                            w_err     = 1'b1;
                            w_errCode = 2'd1;
                        end
                    end else if (r_cmd == CMD_FCWRTEN) begin
                        w_nextState  = ARMED;
                        w_clearFrame = 1'b1;
                        w_err        = 1'b1;
                        w_errCode    = 2'd2;
                    end else begin
                        w_nextState = IDLE;
                        w_err       = 1'b1;
                        w_errCode   = 2'd2;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Shift register and bit counter; a count of 49 marks an overlong frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else if (w_clearFrame) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
        end else if ((r_state == ARMED) && w_sclkRise && !w_latHigh) begin
            r_shift <= {r_shift[46:0], r_sinSync[1]};
            if (r_bitCnt != BITS_OVF) begin
                r_bitCnt <= r_bitCnt + 6'd1;
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcData    <= '0;
            r_fcValid   <= 1'b0;
            r_fcError   <= 1'b0;
            r_fcErrCode <= '0;
        end else begin
            r_fcValid <= w_loadOut;
            r_fcError <= w_err;
            if (w_loadOut) begin
                r_fcData <= r_shift;
            end
            if (w_err) begin
                r_fcErrCode <= w_errCode;
            end
        end
    end

`ifdef LED_FC_RX_ERRCNT_EN
    logic [7:0] r_errCount;

    // Saturating error counter, stepping together with each fc_error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCount <= '0;
        end else if (w_err && (r_errCount != 8'd255)) begin
            r_errCount <= r_errCount + 8'd1;
        end
    end

    assign fc_err_count = r_errCount;
`endif

    assign fc_data     = r_fcData;
    assign fc_valid    = r_fcValid;
    assign fc_error    = r_fcError;
    assign fc_err_code = r_fcErrCode;
    assign armed       = (r_state == ARMED);

endmodule

// File: tb/tb_led_band_fc_receiver.sv
// ---------------------------------------------------------------------------
// tb_led_band_fc_receiver
//
// Self-checking bench for led_band_fc_receiver. Expected fc_valid / fc_error
// events are queued as stimulus is sent and matched by a monitor whenever the
// DUT pulses an output. Build with LED_FC_RX_ERRCNT_EN to also check the
// error counter.
// ---------------------------------------------------------------------------
module tb_led_band_fc_receiver;

    logic        clk;
    logic        rst;
    logic        SCLK;
    logic        SIN;
    logic        LAT;
    logic [47:0] fc_data;
    logic        fc_valid;
    logic        fc_error;
    logic [1:0]  fc_err_code;
    logic        armed;
`ifdef LED_FC_RX_ERRCNT_EN
    logic [7:0]  fc_err_count;
`endif

    typedef struct {
        bit          isErr;
        logic [47:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [47:0] GOOD_A = 48'hA5A5_0F0F_1234;
    localparam logic [47:0] GOOD_B = 48'h5A3C_C3F0_0FED;
    localparam logic [47:0] GOOD_C = 48'h0123_4567_89AB;
    localparam logic [47:0] GOOD_D = 48'hFEDC_BA98_7654;

    led_band_fc_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .SCLK        (SCLK),
        .SIN         (SIN),
        .LAT         (LAT),
        .fc_data     (fc_data),
        .fc_valid    (fc_valid),
        .fc_error    (fc_error),
        .fc_err_code (fc_err_code),
`ifdef LED_FC_RX_ERRCNT_EN
        .fc_err_count(fc_err_count),
`endif
        .armed       (armed)
    );

    // 100 MHz system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit (bad=%0d)", bad);
        $fatal(1, "[TB] timeout");
    end

    // Scoreboard monitor: every output pulse must match the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (fc_valid && fc_error) begin
                total++;
                bad++;
                $display("[TB] FAIL overlap: fc_valid=1 and fc_error=1 in the same cycle");
            end else if (fc_valid || fc_error) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: valid=%0b error=%0b code=%0d, none expected",
                             fc_valid, fc_error, fc_err_code);
                end else begin
                    e = expQ.pop_front();
                    if (e.isErr) begin
                        if (!(fc_error === 1'b1 && fc_err_code === e.code)) begin
                            bad++;
                            $display("[TB] FAIL error_event: got valid=%0b error=%0b code=%0d, want error code=%0d",
                                     fc_valid, fc_error, fc_err_code, e.code);
                        end
                    end else begin
                        if (!(fc_valid === 1'b1 && fc_data === e.data)) begin
                            bad++;
                            $display("[TB] FAIL valid_event: got valid=%0b data=%h, want valid data=%h",
                                     fc_valid, fc_data, e.data);
                        end
                    end
                end
            end
        end
    end

    function automatic void pushValid(input logic [47:0] d);
        exp_t e;
        e.isErr = 1'b0;
        e.data  = d;
        e.code  = 2'd0;
        expQ.push_back(e);
    endfunction

    function automatic void pushErr(input logic [1:0] c);
        exp_t e;
        e.isErr = 1'b1;
        e.data  = '0;
        e.code  = c;
        expQ.push_back(e);
    endfunction

    // One slow SCLK period carrying bit b
    task automatic sclkPulse(input logic b);
        @(negedge clk);
        SIN = b;
        repeat (2) @(negedge clk);
        SCLK = 1'b1;
        repeat (3) @(negedge clk);
        SCLK = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cmdPulses(input int n);
        @(negedge clk);
        LAT = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) sclkPulse(1'b0);
    endtask

    task automatic cmdEnd();
        @(negedge clk);
        LAT = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic sendCmd(input int n);
        cmdPulses(n);
        cmdEnd();
    endtask

    task automatic sendBits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sclkPulse(v[i]);
    endtask

    // Waits a bounded time for all queued events to appear
    task automatic waitDrain(input string name);
        for (int i = 0; i < 40 && expQ.size() != 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_drain: %0d expected events missing, want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        SCLK = 1'b0;
        SIN  = 1'b0;
        LAT  = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (fc_data !== 48'd0 || fc_valid !== 1'b0 || fc_error !== 1'b0 ||
            fc_err_code !== 2'd0 || armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_values: data=%h valid=%0b error=%0b code=%0d armed=%0b, want all 0",
                     fc_data, fc_valid, fc_error, fc_err_code, armed);
        end
`ifdef LED_FC_RX_ERRCNT_EN
        total++;
        if (fc_err_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_errcount: got %0d want 0", fc_err_count);
        end
`endif
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_good_frame();
        int lat;
        sendCmd(15);
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("[TB] FAIL good_armed: got %0b want 1", armed);
        end
        sendBits({16'd0, GOOD_A}, 48);
        pushValid(GOOD_A);
        cmdPulses(5);
        @(negedge clk);
        LAT = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (fc_valid === 1'b1 && lat == 0) lat = i;
        end
        total++;
        if (lat != 4) begin
            bad++;
            $display("[TB] FAIL good_latency: got %0d cycles want 4", lat);
        end
        total++;
        if (fc_data !== GOOD_A || armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL good_data: data=%h armed=%0b, want data=%h armed=0", fc_data, armed, GOOD_A);
        end
        waitDrain("good");
    endtask

    task automatic test_short_frame();
        sendCmd(15);
        sendBits({16'd0, GOOD_B}, 47);
        pushErr(2'd1);
        sendCmd(5);
        waitDrain("short");
        total++;
        if (fc_data !== GOOD_A || fc_err_code !== 2'd1 || armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL short_state: data=%h code=%0d armed=%0b, want data=%h code=1 armed=0",
                     fc_data, fc_err_code, armed, GOOD_A);
        end
    endtask

    task automatic test_long_frame();
        sendCmd(15);
        sendBits(64'hFFF0_1234_5678_9ABC, 60);
        pushErr(2'd1);
        sendCmd(5);
        waitDrain("long");
        total++;
        if (fc_data !== GOOD_A || fc_err_code !== 2'd1) begin
            bad++;
            $display("[TB] FAIL long_state: data=%h code=%0d, want data=%h code=1",
                     fc_data, fc_err_code, GOOD_A);
        end
    endtask

    task automatic test_stray_commands();
        pushErr(2'd3);
        sendCmd(5);
        waitDrain("wrtfc_idle");
        total++;
        if (fc_err_code !== 2'd3 || armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wrtfc_idle_state: code=%0d armed=%0b, want code=3 armed=0", fc_err_code, armed);
        end

        sendCmd(15);
        sendBits(64'h0000_0000_000A_BCDE, 20);
        pushErr(2'd2);
        sendCmd(7);
        waitDrain("other_armed");
        total++;
        if (fc_err_code !== 2'd2 || armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL other_armed_state: code=%0d armed=%0b, want code=2 armed=0", fc_err_code, armed);
        end

        sendCmd(15);
        pushErr(2'd2);
        sendCmd(15);
        total++;
        if (armed !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rearm_armed: got %0b want 1", armed);
        end
        sendBits({16'd0, GOOD_B}, 48);
        pushValid(GOOD_B);
        sendCmd(5);
        waitDrain("rearm");
        total++;
        if (fc_data !== GOOD_B) begin
            bad++;
            $display("[TB] FAIL rearm_data: got %h want %h", fc_data, GOOD_B);
        end
    endtask

    task automatic test_reset_mid_frame();
        sendCmd(15);
        sendBits({16'd0, GOOD_C}, 30);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (fc_data !== 48'd0 || armed !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid: data=%h armed=%0b, want data=0 armed=0", fc_data, armed);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (fc_data !== 48'd0 || fc_err_code !== 2'd0) begin
            bad++;
            $display("[TB] FAIL reset_release: data=%h code=%0d, want data=0 code=0", fc_data, fc_err_code);
        end
        sendCmd(15);
        sendBits({16'd0, GOOD_C}, 48);
        pushValid(GOOD_C);
        sendCmd(5);
        waitDrain("after_reset");
        total++;
        if (fc_data !== GOOD_C) begin
            bad++;
            $display("[TB] FAIL after_reset_data: got %h want %h", fc_data, GOOD_C);
        end
    endtask

    task automatic test_err_count();
        for (int i = 0; i < 3; i++) begin
            pushErr(2'd3);
            sendCmd(5);
        end
        sendCmd(15);
        sendBits({16'd0, GOOD_D}, 48);
        pushValid(GOOD_D);
        sendCmd(5);
        waitDrain("errcount");
        total++;
        if (fc_data !== GOOD_D) begin
            bad++;
            $display("[TB] FAIL errcount_data: got %h want %h", fc_data, GOOD_D);
        end
`ifdef LED_FC_RX_ERRCNT_EN
        total++;
        if (fc_err_count !== 8'd3) begin
            bad++;
            $display("[TB] FAIL errcount_value: got %0d want 3", fc_err_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_long_frame();
        test_stray_commands();
        test_reset_mid_frame();
        test_err_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_band_fc_receiver.md
LED_BAND_FC_RECEIVER -- requirements
Module: led_band_FC_receiver

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: system clock; every register updates on the rising edge.
REQ-003 Port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-004 Port `SCLK`, input, 1 bit: LED-band serial clock, asynchronous to `clk`.
REQ-005 Port `SIN`, input, 1 bit: serial data line, MSB first.
REQ-006 Port `LAT`, input, 1 bit: latch/command line.
REQ-007 Port `fc_data`, output, 48 bits: last FC word accepted.
REQ-008 Port `fc_valid`, output, 1 bit: one-`clk` pulse when `fc_data` updates.
REQ-009 Port `fc_error`, output, 1 bit: one-`clk` pulse when a frame is rejected.
REQ-010 Port `fc_err_code`, output, 2 bits: cause of the last error, held until the next error.
REQ-011 Port `armed`, output, 1 bit: high while FC data is being received.

Function
REQ-012 The block SHALL pass `SCLK`, `SIN` and `LAT` through identical 2-flop synchronisers; an SCLK rising edge is detected as synchronised SCLK high while its previous-cycle value was low.
REQ-013 A 5-bit latch counter SHALL increment on each SCLK rising edge that occurs while synchronised `LAT` is high, and SHALL saturate at 31.
REQ-014 When synchronised `LAT` goes high and an SCLK rising edge occur in the same cycle, that edge SHALL be counted.
REQ-015 On the first cycle with synchronised `LAT` low and a non-zero counter, the counter value SHALL be decoded as a command, and the counter SHALL clear in the same cycle.
- FCWRTEN = 15
- WRTFC = 5
- any other non-zero value = OTHER
REQ-016 The state machine SHALL have two states, IDLE and ARMED; `armed` SHALL be 1 exactly in ARMED.
REQ-017 In IDLE, FCWRTEN SHALL move the machine to ARMED and clear the shift register and the 6-bit bit counter.
REQ-018 In IDLE, WRTFC SHALL pulse `fc_error` with code 3 and leave the state unchanged; OTHER SHALL be ignored.
REQ-019 In ARMED, each SCLK rising edge with `LAT` low SHALL shift synchronised `SIN` into bit 0 of the 48-bit shift register (earlier bits move toward bit 47).
REQ-020 In ARMED, the bit counter SHALL saturate at 49; a count of 49 means overflow.
REQ-021 In ARMED, WRTFC with bit counter exactly 48 SHALL load the shift register into `fc_data` and pulse `fc_valid` 1 `clk` after decode, then return to IDLE.
REQ-022 In ARMED, WRTFC with any other bit count SHALL pulse `fc_error` with code 1, leave `fc_data` unchanged, and return to IDLE.
REQ-023 In ARMED, FCWRTEN SHALL pulse `fc_error` with code 2 and restart ARMED with the shift register and bit counter cleared; OTHER SHALL pulse `fc_error` with code 2 and return to IDLE.
REQ-024 `fc_valid` and `fc_error` SHALL never be high in the same cycle.
REQ-025 Total latency from the `SIN`/`LAT` pin to `fc_valid` SHALL be 4 `clk` cycles: 2 synchroniser stages, 1 decode stage and 1 output register.

Reset
REQ-026 Asserting `rst` SHALL immediately set:
- state = IDLE
- `fc_data` = 0
- `fc_valid` = 0, `fc_error` = 0, `fc_err_code` = 0, `armed` = 0
- all counters, the shift register and the synchronisers = 0
REQ-027 A reset during ARMED SHALL discard the partial frame, and no `fc_valid` or `fc_error` pulse SHALL follow reset release.
REQ-028 After reset release, the first detectable SCLK edge SHALL be no earlier than 3 `clk` cycles later, so a synchroniser holding a stale 0 cannot create a false edge.

Configuration
REQ-029 When macro `LED_FC_RX_ERRCNT_EN` is defined, the block SHALL add output `fc_err_count` (8 bits, reset 0), which increments on each `fc_error` pulse and saturates at 255.
REQ-030 When `LED_FC_RX_ERRCNT_EN` is not defined, port `fc_err_count` and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Good frame: LAT high for 15 SCLK, then 48 bits of 0xA5A5_0F0F_1234 MSB first with LAT low, then LAT high for 5 SCLK -> `fc_data`=0xA5A5_0F0F_1234, a single `fc_valid` pulse, `armed` back to 0.
REQ-032 Short frame: FCWRTEN, 47 bits, WRTFC -> `fc_error` pulse, `fc_err_code`=1, `fc_data` unchanged.
REQ-033 Long frame: FCWRTEN, 60 bits, WRTFC -> `fc_err_code`=1 and no `fc_valid`.
REQ-034 Stray commands: WRTFC in IDLE -> code 3; FCWRTEN, 20 bits, LAT high for 7 SCLK -> code 2 and IDLE; FCWRTEN twice, then 48 bits, then WRTFC -> one code-2 error, then `fc_valid` with correct data.
REQ-035 Reset mid-frame: assert `rst` after bit 30, release, then send a good frame -> `fc_data`=0 during reset, no pulse on release, then `fc_valid` with the new data.
REQ-036 With `LED_FC_RX_ERRCNT_EN` defined, 3 errors followed by 1 good frame -> `fc_err_count`=3; with it undefined, the same bench without that check passes.
